// File: rtl/ysyx_22041211_ifu_sram_if.sv
// AXI-lite style read channel (AR + R) between an instruction fetch initiator
// and the fetch SRAM responder.
interface ysyx_22041211_ifu_sram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] addr_r_addr_i;
  logic                  addr_r_valid_i;
  logic                  addr_r_ready_o;
  logic [DATA_WIDTH-1:0] r_data_o;
  logic [1:0]            r_resp_o;
  logic                  r_valid_o;
  logic                  r_ready_i;

  modport master (
    output addr_r_addr_i,
    output addr_r_valid_i,
    input  addr_r_ready_o,
    input  r_data_o,
    input  r_resp_o,
    input  r_valid_o,
    output r_ready_i
  );

  modport slave (
    input  addr_r_addr_i,
    input  addr_r_valid_i,
    output addr_r_ready_o,
    output r_data_o,
    output r_resp_o,
    output r_valid_o,
    input  r_ready_i
  );

endinterface

// File: rtl/ysyx_22041211_ifu_sram.sv
// Single-outstanding read responder backed by a preloadable word array.
// Fixed LATENCY wait cycles between address accept and the response beat.
module ysyx_22041211_ifu_sram #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    LATENCY    = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  ysyx_22041211_ifu_sram_if.slave  bus,
  input  logic                     init_we_i,
  input  logic [$clog2(DEPTH)-1:0] init_addr_i,
  input  logic [DATA_WIDTH-1:0]    init_data_i
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   r_data_q;
  logic [1:0]              r_resp_q;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [ADDR_WIDTH-1:0]   rd_off;
  logic [ADDR_WIDTH-1:0]   rd_word;
  logic                    rd_err;
  logic [IDX_W-1:0]        rd_idx;
  logic                    capture;

  // With zero latency the response is captured on the accept edge itself,
  // before addr_q holds the address, so decode straight from the bus.
  assign rd_addr = (LATENCY == 0) ? bus.addr_r_addr_i : addr_q;
  assign rd_off  = rd_addr - BASE_ADDR;
  assign rd_word = rd_off >> 2;
  assign rd_idx  = rd_word[IDX_W-1:0];
  assign rd_err  = (rd_addr < BASE_ADDR)
                 | (rd_word >= ADDR_WIDTH'(DEPTH))
                 | (rd_addr[1:0] != 2'b00);

  assign capture = ((state_q == IDLE) && bus.addr_r_valid_i && (LATENCY == 0))
                 | ((state_q == DELAY) && (cnt_q == '0));

  assign bus.addr_r_ready_o = (state_q == IDLE);
  assign bus.r_valid_o      = (state_q == RESP);
  assign bus.r_data_o       = r_data_q;
  assign bus.r_resp_o       = r_resp_q;

  // Preload port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (init_we_i) begin
      mem[init_addr_i] <= init_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      r_data_q <= '0;
      r_resp_q <= 2'b00;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.addr_r_valid_i) begin
            addr_q <= bus.addr_r_addr_i;
            if (LATENCY == 0) begin
              state_q <= RESP;
            end else begin
              state_q <= DELAY;
              cnt_q   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        DELAY: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (bus.r_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Array read shares the edge with any preload write, so a colliding
      // write is seen only by later reads.
      if (capture) begin
        r_resp_q <= rd_err ? 2'b10 : 2'b00;
        r_data_q <= rd_err ? '0 : mem[rd_idx];
      end
    end
  end

endmodule

// File: doc/ysyx_22041211_ifu_sram.md
YSYX_22041211_IFU_SRAM -- requirements
Module: ysyx_22041211_ifu_sram

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: AXI-lite read address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: read data width, one word per beat.
REQ-003 SHALL have parameter DEPTH, default 1024: number of DATA_WIDTH words in the internal array.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h8000_0000: byte address of word 0.
REQ-005 SHALL have parameter LATENCY, default 2: extra wait cycles from address accept to r_valid_o.
REQ-006 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-008 SHALL have port addr_r_addr_i, input, ADDR_WIDTH: read byte address, sampled at the AR handshake.
REQ-009 SHALL have port addr_r_valid_i, input, 1: initiator address valid.
REQ-010 SHALL have port addr_r_ready_o, output, 1: responder accepts the address.
REQ-011 SHALL have port r_data_o, output, DATA_WIDTH: read data.
REQ-012 SHALL have port r_resp_o, output, 2: 2'b00 OKAY, 2'b10 SLVERR.
REQ-013 SHALL have port r_valid_o, output, 1: read data valid.
REQ-014 SHALL have port r_ready_i, input, 1: initiator accepts the data.
REQ-015 SHALL have port init_we_i, input, 1: preload write enable.
REQ-016 SHALL have port init_addr_i, input, $clog2(DEPTH): preload word index.
REQ-017 SHALL have port init_data_i, input, DATA_WIDTH: preload write data.

Function
REQ-018 SHALL have three states: IDLE, DELAY, RESP.
REQ-019 SHALL drive addr_r_ready_o = 1 only in IDLE, decoded from the state register (registered, not combinational from inputs).
REQ-020 SHALL register addr_r_addr_i on the edge where addr_r_valid_i & addr_r_ready_o (the AR handshake).
REQ-021 On AR handshake with LATENCY=0: IDLE->RESP; with LATENCY>0: IDLE->DELAY and a down-counter loaded with LATENCY-1.
REQ-022 In DELAY: count down each cycle; at count 0 go to RESP; r_valid_o is 0 throughout DELAY.
REQ-023 The cycle count from the AR handshake edge to the first cycle of r_valid_o=1 SHALL be exactly LATENCY+1 edges.
REQ-024 SHALL register r_data_o and r_resp_o on the edge entering RESP, from the array word for the latched address.
REQ-025 Word index = (addr - BASE_ADDR) >> 2, computed at ADDR_WIDTH width; the subtraction wraps modulo 2^ADDR_WIDTH.
REQ-026 Out of range (addr < BASE_ADDR or index >= DEPTH) or addr[1:0] != 0: r_resp_o = 2'b10, r_data_o = 0.
REQ-027 Otherwise: r_resp_o = 2'b00, r_data_o = array word.
REQ-028 r_valid_o = 1 exactly in RESP; r_data_o and r_resp_o SHALL hold stable while r_valid_o=1 and r_ready_i=0.
REQ-029 On r_valid_o & r_ready_i: RESP->IDLE; the next address is accepted no earlier than the following cycle (at most one outstanding read).
REQ-030 addr_r_valid_i asserted outside IDLE SHALL be ignored; it is not queued.
REQ-031 r_ready_i asserted before r_valid_o SHALL have no effect.
REQ-032 init_we_i SHALL write init_data_i to init_addr_i on the rising edge, in any state.
REQ-033 If a preload write and the RESP-entry capture hit the same word on the same edge, the pre-write (old) data SHALL be returned.
REQ-034 Array contents SHALL not be reset.

Reset
REQ-035 With rst=1, the state SHALL go to IDLE immediately (asynchronously), the counter SHALL clear, and outputs SHALL be: addr_r_ready_o=1, r_valid_o=0, r_data_o=0, r_resp_o=2'b00.
REQ-036 A reset during DELAY or RESP SHALL abort the transaction with no response beat after release.
REQ-037 After rst falls, a handshake is accepted on the first rising edge.

Verification
REQ-038 Preload word 0 = 32'h0000_0413, LATENCY=2, read 32'h8000_0000 with r_ready_i=1 -> r_valid_o rises 3 edges after handshake, data 32'h0000_0413, resp 00.
REQ-039 Read 32'h8000_0004 with r_ready_i held 0 for 5 cycles -> r_valid_o stays 1, data and resp stable, addr_r_ready_o=0; IDLE 1 cycle after r_ready_i=1.
REQ-040 Read 32'h7FFF_FFFC, 32'h8000_1000 (DEPTH=1024) and 32'h8000_0002 -> each returns resp 2'b10, data 0.
REQ-041 LATENCY=0 back-to-back reads, valid and ready always 1 -> one beat every 2 cycles, data in order.
REQ-042 Assert rst during DELAY -> r_valid_o=0 at once, addr_r_ready_o=1, no beat after release; a fresh read returns correct data.
REQ-043 Preload write to word 1 on the RESP-entry edge of a read of word 1 -> old value returned; the next read returns the new value.
